// File: rtl/apu_power_ctrl.sv
// APU power controller: owns the NR52 master enable, forwards CPU writes to
// the FF10-FF25 register bank and to wave RAM, and on power-off walks the
// register bank writing zero, one register per clock.
//
// Handshake: there is no back-pressure. cpu_wr is a one-clock request that is
// always consumed on the edge that samples it. reg_we and wave_we are
// one-clock strobes, valid for exactly the cycle they are high, and the
// receiving bank must accept them unconditionally.
module apu_power_ctrl #(
   parameter logic       RESET_ON  = 1'b1,
   parameter logic [5:0] FIRST_REG = 6'h10,
   parameter logic [5:0] LAST_REG  = 6'h25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] a,
   input  logic [7:0]  d,
   input  logic        cpu_wr,
   input  logic [3:0]  ch_active,
   output logic        reg_we,
   output logic [5:0]  reg_sel,
   output logic [7:0]  reg_wdata,
   output logic        wave_we,
   output logic [3:0]  wave_addr,
   output logic [7:0]  wave_wdata,
   output logic        apu_on,
   output logic        clearing,
   output logic        seq_rst,
   output logic [7:0]  nr52_rdata
);

   typedef enum logic [1:0] {
      ST_ON  = 2'd0,
      ST_OFF = 2'd1,
      ST_CLR = 2'd2
   } state_t;

   state_t     state;
   logic [5:0] ptr;        // next register the clear walk will write
   logic       walk_done;  // the LAST_REG strobe has been issued
   logic       pend;       // power-on requested while the walk runs

   logic page_hit;
   logic reg_hit;
   logic pwr_hit;
   logic wave_hit;
   logic pend_next;

   // Address decode of the current CPU write; FF15 and FF1F are unmapped holes.
   always_comb begin
      page_hit  = cpu_wr && (a[15:8] == 8'hFF);
      reg_hit   = page_hit && (a[7:0] >= 8'h10) && (a[7:0] <= 8'h25)
                  && (a[7:0] != 8'h15) && (a[7:0] != 8'h1F);
      pwr_hit   = page_hit && (a[7:0] == 8'h26);
      wave_hit  = page_hit && (a[7:4] == 4'h3);
      pend_next = pwr_hit ? d[7] : pend;
   end

   // Walk pointer step, hopping over the two unmapped offsets.
   function automatic logic [5:0] next_ptr(input logic [5:0] p);
      logic [5:0] n;
      n = p + 6'd1;
      if ((n == 6'h15) || (n == 6'h1F)) begin
         n = n + 6'd1;
      end
      return n;
   endfunction

   // NR52 read value; apu_on is already low for the whole walk.
   assign nr52_rdata = {apu_on, 3'b111, ch_active};

   // Power state machine with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RESET_ON ? ST_ON : ST_OFF;
         ptr        <= 6'd0;
         walk_done  <= 1'b0;
         pend       <= 1'b0;
         reg_we     <= 1'b0;
         reg_sel    <= 6'd0;
         reg_wdata  <= 8'd0;
         wave_we    <= 1'b0;
         wave_addr  <= 4'd0;
         wave_wdata <= 8'd0;
         apu_on     <= RESET_ON;
         clearing   <= 1'b0;
         seq_rst    <= 1'b0;
      end else begin
         reg_we  <= 1'b0;
         wave_we <= 1'b0;
         seq_rst <= 1'b0;

         // Wave RAM is outside the power domain and never waits on the walk.
         if (wave_hit) begin
            wave_we    <= 1'b1;
            wave_addr  <= a[3:0];
            wave_wdata <= d;
         end

         case (state)
            ST_ON: begin
               if (reg_hit) begin
                  reg_we    <= 1'b1;
                  reg_sel   <= a[5:0];
                  reg_wdata <= d;
               end else if (pwr_hit && !d[7]) begin
                  // The first walk strobe goes out on the power-off edge itself.
                  state     <= ST_CLR;
                  apu_on    <= 1'b0;
                  clearing  <= 1'b1;
                  reg_we    <= 1'b1;
                  reg_sel   <= FIRST_REG;
                  reg_wdata <= 8'd0;
                  ptr       <= next_ptr(FIRST_REG);
                  walk_done <= (FIRST_REG == LAST_REG);
                  pend      <= 1'b0;
               end
            end

            ST_CLR: begin
               if (!walk_done) begin
                  // CPU register writes are dropped; the walk owns the bank.
                  reg_we    <= 1'b1;
                  reg_sel   <= ptr;
                  reg_wdata <= 8'd0;
                  ptr       <= next_ptr(ptr);
                  walk_done <= (ptr == LAST_REG);
                  pend      <= pend_next;
               end else begin
                  // Writes sampled during the final strobe still count here.
                  state     <= pend_next ? ST_ON : ST_OFF;
                  apu_on    <= pend_next;
                  seq_rst   <= pend_next;
                  clearing  <= 1'b0;
                  walk_done <= 1'b0;
                  pend      <= 1'b0;
               end
            end

            ST_OFF: begin
               if (pwr_hit && d[7]) begin
                  state   <= ST_ON;
                  apu_on  <= 1'b1;
                  seq_rst <= 1'b1;
               end
            end

            default: begin
               state <= ST_OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apu_power_ctrl.sv
// Bench for apu_power_ctrl: a vector table for single-cycle register and
// wave writes while powered, then hand-written sequences for the clear walk,
// pending power-on, the OFF state and reset in the middle of a walk.
module tb_apu_power_ctrl;

   localparam int W = 39;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] a = 16'h0000;
   logic [7:0]  d = 8'h00;
   logic        cpu_wr = 1'b0;
   logic [3:0]  ch = 4'h0;

   logic        reg_we;
   logic [5:0]  reg_sel;
   logic [7:0]  reg_wdata;
   logic        wave_we;
   logic [3:0]  wave_addr;
   logic [7:0]  wave_wdata;
   logic        apu_on;
   logic        clearing;
   logic        seq_rst;
   logic [7:0]  nr52_rdata;

   apu_power_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .a          (a),
      .d          (d),
      .cpu_wr     (cpu_wr),
      .ch_active  (ch),
      .reg_we     (reg_we),
      .reg_sel    (reg_sel),
      .reg_wdata  (reg_wdata),
      .wave_we    (wave_we),
      .wave_addr  (wave_addr),
      .wave_wdata (wave_wdata),
      .apu_on     (apu_on),
      .clearing   (clearing),
      .seq_rst    (seq_rst),
      .nr52_rdata (nr52_rdata)
   );

   // Clock and overall time limit
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, want finish before 200000");
      $fatal(1, "timeout");
   end

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   int           n_vec = 0;
   int           n_bad = 0;

   // Held values of the data/address outputs between strobes
   logic [5:0] h_sel = 6'd0;
   logic [7:0] h_wd  = 8'd0;
   logic [3:0] h_wa  = 4'd0;
   logic [7:0] h_wwd = 8'd0;

   logic [5:0] offs [20] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h16, 6'h17,
                             6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D, 6'h1E,
                             6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25};

   wire [W-1:0] act = {reg_we, reg_sel, reg_wdata, wave_we, wave_addr,
                       wave_wdata, apu_on, clearing, seq_rst, nr52_rdata};

   function automatic logic [W-1:0] ex(input logic rwe, input logic [5:0] sel,
                                       input logic [7:0] wd, input logic wwe,
                                       input logic [3:0] wa, input logic [7:0] wwd,
                                       input logic on, input logic clr,
                                       input logic sr);
      if (rwe) begin
         h_sel = sel;
         h_wd  = wd;
      end
      if (wwe) begin
         h_wa  = wa;
         h_wwd = wwd;
      end
      return {rwe, h_sel, h_wd, wwe, h_wa, h_wwd, on, clr, sr, on, 3'b111, ch};
   endfunction

   // Driver: apply one cycle of inputs, then check the outputs 1 after the edge
   task automatic step(input logic [15:0] ai, input logic [7:0] di,
                       input logic wi, input logic ri,
                       input logic [W-1:0] e, input string nm);
      logic [W-1:0] want;
      @(negedge clk);
      a      = ai;
      d      = di;
      cpu_wr = wi;
      reset  = ri;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (we,sel,wd,wwe,wa,wwd,on,clr,sr,nr52)",
                  nm, act, want);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        wr;
      logic [3:0]  ch;
      logic        rwe;
      logic [5:0]  sel;
      logic [7:0]  wd;
      logic        wwe;
      logic [3:0]  wa;
      logic [7:0]  wwd;
      string       nm;
   } vec_t;

   vec_t tbl [11];

   initial begin
      // Writes while powered: forwarded, holes ignored, foreign pages ignored
      tbl[0]  = '{16'hFF12, 8'hF3, 1'b1, 4'h0, 1'b1, 6'h12, 8'hF3, 1'b0, 4'h0, 8'h00, "on_ff12"};
      tbl[1]  = '{16'hFF15, 8'hAA, 1'b1, 4'h0, 1'b0, 6'h00, 8'h00, 1'b0, 4'h0, 8'h00, "on_ff15_hole"};
      tbl[2]  = '{16'hFF1F, 8'hAA, 1'b1, 4'h0, 1'b0, 6'h00, 8'h00, 1'b0, 4'h0, 8'h00, "on_ff1f_hole"};
      tbl[3]  = '{16'hFF27, 8'hAA, 1'b1, 4'h0, 1'b0, 6'h00, 8'h00, 1'b0, 4'h0, 8'h00, "on_ff27_unmapped"};
      tbl[4]  = '{16'hFF26, 8'h80, 1'b1, 4'h0, 1'b0, 6'h00, 8'h00, 1'b0, 4'h0, 8'h00, "on_pwr_on_noop"};
      tbl[5]  = '{16'h1012, 8'h55, 1'b1, 4'h0, 1'b0, 6'h00, 8'h00, 1'b0, 4'h0, 8'h00, "on_other_page"};
      tbl[6]  = '{16'hFF13, 8'h66, 1'b0, 4'h0, 1'b0, 6'h00, 8'h00, 1'b0, 4'h0, 8'h00, "on_no_strobe"};
      tbl[7]  = '{16'hFF3F, 8'hC3, 1'b1, 4'hA, 1'b0, 6'h00, 8'h00, 1'b1, 4'hF, 8'hC3, "on_wave_ff3f"};
      tbl[8]  = '{16'hFF25, 8'h99, 1'b1, 4'h5, 1'b1, 6'h25, 8'h99, 1'b0, 4'h0, 8'h00, "on_ff25_last"};
      tbl[9]  = '{16'hFF10, 8'h01, 1'b1, 4'h0, 1'b1, 6'h10, 8'h01, 1'b0, 4'h0, 8'h00, "on_ff10_first"};
      tbl[10] = '{16'hFF30, 8'h12, 1'b1, 4'h0, 1'b0, 6'h00, 8'h00, 1'b1, 4'h0, 8'h12, "on_wave_ff30"};

      // Reset values
      step(16'h0000, 8'h00, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 1, 0, 0), "reset_0");
      step(16'h0000, 8'h00, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 1, 0, 0), "reset_1");
      step(16'h0000, 8'h00, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0), "after_reset");

      for (int i = 0; i < 11; i++) begin
         ch = tbl[i].ch;
         step(tbl[i].a, tbl[i].d, tbl[i].wr, 1'b0,
              ex(tbl[i].rwe, tbl[i].sel, tbl[i].wd, tbl[i].wwe, tbl[i].wa,
                 tbl[i].wwd, 1, 0, 0), tbl[i].nm);
      end
      ch = 4'h0;

      // Walk 1: power-on request then cancelled, wave write mid-walk -> OFF
      step(16'hFF26, 8'h00, 1'b1, 1'b0, ex(1, offs[0], 0, 0, 0, 0, 0, 1, 0), "walk1_s0");
      for (int i = 1; i < 20; i++) begin
         if (i == 3)
            step(16'hFF26, 8'h80, 1'b1, 1'b0, ex(1, offs[i], 0, 0, 0, 0, 0, 1, 0),
                 $sformatf("walk1_s%0d", i));
         else if (i == 6)
            step(16'hFF26, 8'h00, 1'b1, 1'b0, ex(1, offs[i], 0, 0, 0, 0, 0, 1, 0),
                 $sformatf("walk1_s%0d", i));
         else if (i == 9)
            step(16'hFF31, 8'h11, 1'b1, 1'b0, ex(1, offs[i], 0, 1, 4'h1, 8'h11, 0, 1, 0),
                 $sformatf("walk1_s%0d", i));
         else
            step(16'h0000, 8'h00, 1'b0, 1'b0, ex(1, offs[i], 0, 0, 0, 0, 0, 1, 0),
                 $sformatf("walk1_s%0d", i));
      end
      step(16'h0000, 8'h00, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "walk1_exit_off");

      // OFF: register writes dropped, wave forwarded, power-off ignored
      step(16'hFF11, 8'h80, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "off_ff11_drop");
      step(16'hFF3A, 8'h5C, 1'b1, 1'b0, ex(0, 0, 0, 1, 4'hA, 8'h5C, 0, 0, 0), "off_wave_ff3a");
      step(16'hFF26, 8'h00, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "off_pwr_off_noop");
      step(16'hFF26, 8'h80, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0, 1), "off_power_on");
      step(16'h0000, 8'h00, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0), "seq_rst_one_clk");

      // Walk 2: pending power-on, dropped FF24, dropped write at final strobe
      step(16'hFF26, 8'h00, 1'b1, 1'b0, ex(1, offs[0], 0, 0, 0, 0, 0, 1, 0), "walk2_s0");
      for (int i = 1; i < 20; i++) begin
         if (i == 5)
            step(16'hFF26, 8'h80, 1'b1, 1'b0, ex(1, offs[i], 0, 0, 0, 0, 0, 1, 0),
                 $sformatf("walk2_s%0d", i));
         else if (i == 7)
            step(16'hFF24, 8'h77, 1'b1, 1'b0, ex(1, offs[i], 0, 0, 0, 0, 0, 1, 0),
                 $sformatf("walk2_s%0d", i));
         else
            step(16'h0000, 8'h00, 1'b0, 1'b0, ex(1, offs[i], 0, 0, 0, 0, 0, 1, 0),
                 $sformatf("walk2_s%0d", i));
      end
      step(16'hFF12, 8'h44, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0, 1), "walk2_exit_on");
      step(16'hFF24, 8'h77, 1'b1, 1'b0, ex(1, 6'h24, 8'h77, 0, 0, 0, 1, 0, 0), "walk2_after_on");
      step(16'h0000, 8'h00, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0), "walk2_quiet");

      // Walk 3: reset during the 5th strobe aborts the walk
      step(16'hFF26, 8'h00, 1'b1, 1'b0, ex(1, offs[0], 0, 0, 0, 0, 0, 1, 0), "walk3_s0");
      for (int i = 1; i < 5; i++) begin
         step(16'h0000, 8'h00, 1'b0, 1'b0, ex(1, offs[i], 0, 0, 0, 0, 0, 1, 0),
              $sformatf("walk3_s%0d", i));
      end
      h_sel = 6'd0;
      h_wd  = 8'd0;
      h_wa  = 4'd0;
      h_wwd = 8'd0;
      step(16'h0000, 8'h00, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 1, 0, 0), "walk3_reset");
      for (int i = 0; i < 3; i++) begin
         step(16'h0000, 8'h00, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0),
              $sformatf("walk3_no_strobe%0d", i));
      end

      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
